// File: rtl/scram_pkg.sv
// Shared constants, mode type and pointer helper for the lane scrambler scheduler.
// Optional descramble mode is enabled with SCRAM_SCHED_DESCRAM_EN.
package scram_pkg;

  localparam int STATE_W = 3;
  localparam int TAP_A   = 1;
  localparam int TAP_B   = 0;

  typedef enum logic {
    SCRAM   = 1'b0,
    DESCRAM = 1'b1
  } scram_mode_t;

  function automatic int unsigned next_ptr(
    input int unsigned p,
    input int unsigned n
  );
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/scram_step.sv
// One parallel W-bit step of the self-synchronising scrambler, MSB first.
// Descramble history selection exists only under SCRAM_SCHED_DESCRAM_EN.
module scram_step
  import scram_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]       d_i,
  input  logic [STATE_W-1:0] h_i,
`ifdef SCRAM_SCHED_DESCRAM_EN
  input  scram_mode_t        mode_i,
`endif
  output logic [W-1:0]       y_o,
  output logic [STATE_W-1:0] h_next_o
);

  logic [STATE_W-1:0] h;
  logic               fb;

  always_comb begin
    h  = h_i;
    y_o = '0;
    fb = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      y_o[i] = d_i[i] ^ h[TAP_A] ^ h[TAP_B];
`ifdef SCRAM_SCHED_DESCRAM_EN
      fb = (mode_i == DESCRAM) ? d_i[i] : y_o[i];
`else
      fb = y_o[i];
`endif
      h = {fb, h[STATE_W-1:1]};
    end
    h_next_o = h;
  end

endmodule

// File: rtl/scram_lane_sched.sv
// Round-robin scheduler sharing one scrambler step across NLANES lanes.
// Per-lane descramble select is built only with SCRAM_SCHED_DESCRAM_EN.
module scram_lane_sched
  import scram_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int W      = 4,
  parameter int LW     = $clog2(NLANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NLANES-1:0]    in_valid,
  input  logic [NLANES*W-1:0]  in_data,
  output logic [NLANES-1:0]    in_ready,
  input  logic                 seed_valid,
  input  logic [LW-1:0]        seed_lane,
  input  logic [STATE_W-1:0]   seed_val,
`ifdef SCRAM_SCHED_DESCRAM_EN
  input  logic [NLANES-1:0]    cfg_descram,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [LW-1:0]        out_lane
);

  logic [LW-1:0]      ptr_q;
  logic [LW-1:0]      ptr_d;
  logic [LW-1:0]      gnt_idx;
  logic               gnt_found;
  logic               slot_free;
  logic               grant;
  logic [STATE_W-1:0] hist_q [NLANES];
  logic               out_valid_q;
  logic [W-1:0]       out_data_q;
  logic [W-1:0]       out_data_d;
  logic [LW-1:0]      out_lane_q;
  logic [W-1:0]       d_sel;
  logic [STATE_W-1:0] h_sel;
  logic [STATE_W-1:0] h_next;
  int unsigned        j;

  assign slot_free = !out_valid_q || out_ready;

  // First valid lane at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < NLANES; k++) begin
      j = 32'(ptr_q) + 32'(k);
      if (j >= NLANES) j = j - NLANES;
      if (!gnt_found && in_valid[j[LW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[LW-1:0];
      end
    end
  end

  assign grant    = gnt_found && slot_free && rst_n;
  assign in_ready = grant ? (NLANES'(1) << gnt_idx) : '0;
  assign d_sel    = in_data[gnt_idx*W +: W];
  assign h_sel    = hist_q[gnt_idx];
  assign ptr_d    = LW'(next_ptr(32'(gnt_idx), NLANES));

`ifdef SCRAM_SCHED_DESCRAM_EN
  scram_mode_t mode_sel;
  assign mode_sel = cfg_descram[gnt_idx] ? DESCRAM : SCRAM;
`endif

  scram_step #(
    .W(W)
  ) u_step (
    .d_i     (d_sel),
    .h_i     (h_sel),
`ifdef SCRAM_SCHED_DESCRAM_EN
    .mode_i  (mode_sel),
`endif
    .y_o     (out_data_d),
    .h_next_o(h_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < NLANES; i++) hist_q[i] <= '0;
    end else begin
      if (grant) begin
        out_valid_q     <= 1'b1;
        out_data_q      <= out_data_d;
        out_lane_q      <= gnt_idx;
        ptr_q           <= ptr_d;
        hist_q[gnt_idx] <= h_next;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      // Seed is written last so it overrides a same-cycle grant update.
      if (seed_valid && 32'(seed_lane) < 32'(NLANES))
        hist_q[seed_lane] <= seed_val;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;

endmodule

// File: tb/tb_scram_lane_sched.sv
// Directed plus randomized bench for scram_lane_sched against a bit-sequence model.
// Descramble scenarios run only when SCRAM_SCHED_DESCRAM_EN is defined.
module tb_scram_lane_sched;

  localparam int NL = 4;
  localparam int W  = 4;
  localparam int LW = 2;

  logic              clk;
  logic              rst_n;
  logic [NL-1:0]     in_valid;
  logic [NL*W-1:0]   in_data;
  logic [NL-1:0]     in_ready;
  logic              seed_valid;
  logic [LW-1:0]     seed_lane;
  logic [2:0]        seed_val;
`ifdef SCRAM_SCHED_DESCRAM_EN
  logic [NL-1:0]     cfg_descram;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [LW-1:0]     out_lane;

  int n_tests;
  int n_fail;

  scram_lane_sched #(
    .NLANES(NL),
    .W     (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .seed_valid (seed_valid),
    .seed_lane  (seed_lane),
    .seed_val   (seed_val),
`ifdef SCRAM_SCHED_DESCRAM_EN
    .cfg_descram(cfg_descram),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [2:0]   m_hist [NL];
  int           m_ptr;
  bit           m_ov;
  logic [W-1:0] m_data;
  int           m_lane;

  // Serial bit-sequence view: s[0..2] is the old history (oldest first),
  // each new history bit appended; taps are n-2 and n-3.
  function automatic void ref_word(
    input  logic [W-1:0] d,
    input  logic [2:0]   h,
    input  bit           desc,
    output logic [W-1:0] y,
    output logic [2:0]   hn
  );
    bit s [W+3];
    bit dn;
    bit yn;
    s[0] = h[0];
    s[1] = h[1];
    s[2] = h[2];
    y = '0;
    for (int n = 0; n < W; n++) begin
      dn = d[W-1-n];
      yn = dn ^ s[n+1] ^ s[n];
      y[W-1-n] = yn;
      s[n+3] = desc ? dn : yn;
    end
    hn = {s[W+2], s[W+1], s[W]};
  endfunction

  function automatic bit desc_of(input int g);
`ifdef SCRAM_SCHED_DESCRAM_EN
    return cfg_descram[g];
`else
    return (g < 0);
`endif
  endfunction

  function automatic int exp_grant();
    int l;
    if (!rst_n) return -1;
    if (m_ov && !out_ready) return -1;
    for (int k = 0; k < NL; k++) begin
      l = (m_ptr + k) % NL;
      if (in_valid[l]) return l;
    end
    return -1;
  endfunction

  function automatic void model_clock(input int g);
    logic [W-1:0] y;
    logic [2:0]   hn;
    if (!rst_n) begin
      m_ov = 0; m_data = '0; m_lane = 0; m_ptr = 0;
      for (int i = 0; i < NL; i++) m_hist[i] = 3'b000;
      return;
    end
    if (g >= 0) begin
      ref_word(in_data[g*W +: W], m_hist[g], desc_of(g), y, hn);
      m_data = y; m_lane = g; m_ov = 1;
      m_hist[g] = hn;
      m_ptr = (g + 1) % NL;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (seed_valid && int'(seed_lane) < NL) m_hist[seed_lane] = seed_val;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs must already be driven (just after a posedge).
  task automatic step(input string tag);
    int g;
    logic [NL-1:0] er;
    g = exp_grant();
    er = (g >= 0) ? NL'(1) << g : '0;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    model_clock(g);
    #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, "_out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, "_out_lane"}, 32'(out_lane), 32'(m_lane));
  endtask

  task automatic idle();
    in_valid = '0; seed_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ptr = 0; m_ov = 0; m_data = '0; m_lane = 0;
    for (int i = 0; i < NL; i++) m_hist[i] = 3'b000;
    rst_n = 1'b0; in_valid = '0; in_data = '0; seed_valid = 1'b0;
    seed_lane = '0; seed_val = '0; out_ready = 1'b1;
`ifdef SCRAM_SCHED_DESCRAM_EN
    cfg_descram = '0;
`endif
    @(posedge clk);
    #1;
    step("reset0");
    chk("reset_ov_const", 32'(out_valid), 32'd0);
    chk("reset_od_const", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // Lane 0 scramble C then A
    in_valid = 4'b0001; in_data = 16'h000C;
    step("s1_w0");
    chk("s1_w0_const", 32'(out_data), 32'hE);
    in_data = 16'h000A;
    step("s1_w1");
    chk("s1_w1_const", 32'(out_data), 32'hC);
    idle();
    step("s1_idle");

`ifdef SCRAM_SCHED_DESCRAM_EN
    do_reset();
    cfg_descram = 4'b0010;
    in_valid = 4'b0010; in_data = 16'h00E0;
    step("d_w0");
    chk("d_w0_const", 32'(out_data), 32'hC);
    in_data = 16'h00C0;
    step("d_w1");
    chk("d_w1_const", 32'(out_data), 32'hA);
    idle();
    cfg_descram = '0;
    step("d_idle");
`endif

    // Round robin, all lanes valid
    do_reset();
    in_valid = 4'b1111; in_data = 16'h3C5A;
    for (int i = 0; i < 6; i++) step("rr");

    // Backpressure after lane 2 word
    do_reset();
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) step("bp_fill");
    chk("bp_lane2_const", 32'(out_lane), 32'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("bp_hold");
    out_ready = 1'b1;
    step("bp_release");
    chk("bp_lane3_const", 32'(out_lane), 32'd3);
    idle();
    step("bp_idle");

    // Seed collides with a lane 0 grant
    do_reset();
    in_valid = 4'b0001; in_data = 16'h0000;
    seed_valid = 1'b1; seed_lane = 2'd0; seed_val = 3'b111;
    step("seed_w0");
    chk("seed_w0_const", 32'(out_data), 32'h0);
    seed_valid = 1'b0;
    step("seed_w1");

    // Reset while a word is valid
    in_valid = 4'b0110; in_data = 16'h0F70;
    step("mr_fill");
    rst_n = 1'b0;
    step("mr_reset");
    rst_n = 1'b1;
    in_valid = 4'b0001; in_data = 16'h000C;
    step("mr_after");
    chk("mr_after_const", 32'(out_data), 32'hE);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid   = NL'($urandom);
      in_data    = (NL*W)'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      seed_valid = ($urandom_range(0, 7) == 0);
      seed_lane  = LW'($urandom);
      seed_val   = 3'($urandom);
      rst_n      = ($urandom_range(0, 59) != 0);
`ifdef SCRAM_SCHED_DESCRAM_EN
      cfg_descram = NL'($urandom);
`endif
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
